// File: rtl/fixed_to_ascii_converter_if.sv
`default_nettype none
// ============================================================================
// Module      : fixed_to_ascii_converter_if
// Description : Handshake and data bundle between a fixed-point producer, the
//               ASCII converter and the character consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fixed_to_ascii_converter_if #(
    parameter int BITS  = 33,
    parameter int NCHAR = 8
);
    logic                 i_valid;
    logic                 o_ready;
    logic [BITS-1:0]      i_value;
    logic                 o_valid;
    logic                 i_ready;
    logic [NCHAR*8-1:0]   o_chars;
    logic                 o_overflow;

    modport slave (
        input  i_valid, i_value, i_ready,
        output o_ready, o_valid, o_chars, o_overflow
    );

    modport master (
        output i_valid, i_value, i_ready,
        input  o_ready, o_valid, o_chars, o_overflow
    );
endinterface
`default_nettype wire

// File: rtl/fixed_to_ascii_converter.sv
`default_nettype none
// ============================================================================
// Module      : fixed_to_ascii_converter
// Description : Sequential signed Q(INT_BITS.FRACTIONAL_BITS) to ASCII decimal
//               converter (double-dabble integer, times-ten fraction digits).
//               Optional macro F2A_BLANK_ZEROS_EN blanks leading integer zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_to_ascii_converter #(
    parameter int INT_BITS         = 3,
    parameter int FRACTIONAL_BITS  = 30,
    parameter int DISPLAY_INT_NUM  = 2,
    parameter int DISPLAY_FRAC_NUM = 4
) (
    input  wire logic                   i_clk,
    input  wire logic                   i_rst_n,
    fixed_to_ascii_converter_if.slave   io_bus
);
    localparam int c_BITS    = INT_BITS + FRACTIONAL_BITS;
    localparam int c_NCHAR   = DISPLAY_INT_NUM + DISPLAY_FRAC_NUM + 2;
    localparam int c_BCDW    = 4 * (DISPLAY_INT_NUM + 1);
    localparam int c_FDW     = 4 * DISPLAY_FRAC_NUM;
    localparam int c_CNT_MAX = (INT_BITS > DISPLAY_FRAC_NUM) ? INT_BITS : DISPLAY_FRAC_NUM;
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ABS  = 3'd1,
        S_INT  = 3'd2,
        S_FRAC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                     r_state, w_next;
    logic                       r_ready, w_accept;
    logic [c_BITS-1:0]          r_value, w_mag;
    logic                       r_sign;
    logic [INT_BITS-1:0]        r_ishift;
    logic [FRACTIONAL_BITS-1:0] r_frac;
    logic [FRACTIONAL_BITS+3:0] w_prod;
    logic [c_BCDW-1:0]          r_bcd, w_bcd_adj;
    logic [c_FDW-1:0]           r_fdig;
    logic [c_CW-1:0]            r_cnt;
    logic                       w_last_int, w_last_frac, w_ovf;
    logic                       r_valid, r_ovf;
    logic [c_NCHAR*8-1:0]       r_chars, w_chars;
    logic [7:0]                 w_sign_ch;
    int                         w_lead;

    assign w_last_int  = (r_cnt == c_CW'(INT_BITS - 1));
    assign w_last_frac = (r_cnt == c_CW'(DISPLAY_FRAC_NUM - 1));
    assign w_mag       = r_value[c_BITS-1] ? (~r_value + 1'b1) : r_value;
    assign w_prod      = ({4'b0, r_frac} << 3) + ({4'b0, r_frac} << 1);
    assign w_ovf       = |r_bcd[c_BCDW-1 -: 4];
    assign w_sign_ch   = r_sign ? 8'h2D : 8'h2B;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == S_IDLE);
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.i_valid && r_ready) begin
                    w_accept = 1'b1;
                    w_next   = S_ABS;
                end
            end
            S_ABS:  w_next = S_INT;
            S_INT:  if (w_last_int)  w_next = S_FRAC;
            S_FRAC: if (w_last_frac) w_next = S_DONE;
            S_DONE: if (r_valid && io_bus.i_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Add-3 correction applied to every BCD digit ahead of each shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d <= DISPLAY_INT_NUM; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5)
                w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
        end
    end

    always_comb begin
        w_chars = {c_NCHAR{8'h20}};
        w_lead  = 0;
`ifdef F2A_BLANK_ZEROS_EN
        begin
            logic w_run;
            w_run = 1'b1;
            for (int j = 0; j < DISPLAY_INT_NUM - 1; j++) begin
                if (w_run && !w_ovf && (r_bcd[4*(DISPLAY_INT_NUM-1-j) +: 4] == 4'd0))
                    w_lead = j + 1;
                else
                    w_run = 1'b0;
            end
        end
`endif
        // Positions left of w_lead stay blank; the sign sits just before the digits
        for (int p = 0; p <= DISPLAY_INT_NUM; p++) begin
            if (p == w_lead)
                w_chars[(c_NCHAR-1-p)*8 +: 8] = w_sign_ch;
            else if (p > w_lead)
                w_chars[(c_NCHAR-1-p)*8 +: 8] = w_ovf ? 8'h39 :
                    {4'h3, r_bcd[4*(DISPLAY_INT_NUM-p) +: 4]};
        end
        w_chars[(c_NCHAR-2-DISPLAY_INT_NUM)*8 +: 8] = 8'h2E;
        for (int j = 0; j < DISPLAY_FRAC_NUM; j++) begin
            w_chars[(c_NCHAR-3-DISPLAY_INT_NUM-j)*8 +: 8] = w_ovf ? 8'h39 :
                {4'h3, r_fdig[4*(DISPLAY_FRAC_NUM-1-j) +: 4]};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_value  <= '0;
            r_sign   <= 1'b0;
            r_ishift <= '0;
            r_frac   <= '0;
            r_bcd    <= '0;
            r_fdig   <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_chars  <= {c_NCHAR{8'h20}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept)
                        r_value <= io_bus.i_value;
                end
                S_ABS: begin
                    r_sign   <= r_value[c_BITS-1];
                    r_ishift <= w_mag[c_BITS-1:FRACTIONAL_BITS];
                    r_frac   <= w_mag[FRACTIONAL_BITS-1:0];
                    r_bcd    <= '0;
                    r_fdig   <= '0;
                    r_cnt    <= '0;
                end
                S_INT: begin
                    r_bcd    <= {w_bcd_adj[c_BCDW-2:0], r_ishift[INT_BITS-1]};
                    r_ishift <= r_ishift << 1;
                    r_cnt    <= w_last_int ? '0 : r_cnt + 1'b1;
                end
                S_FRAC: begin
                    r_frac <= w_prod[FRACTIONAL_BITS-1:0];
                    r_fdig <= (r_fdig << 4) | c_FDW'(w_prod[FRACTIONAL_BITS+3:FRACTIONAL_BITS]);
                    r_cnt  <= w_last_frac ? '0 : r_cnt + 1'b1;
                end
                S_DONE: begin
                    // First DONE cycle publishes the result; later cycles wait for the consumer
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                        r_chars <= w_chars;
                        r_ovf   <= w_ovf;
                    end else if (io_bus.i_ready) begin
                        r_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_bus.o_ready    = r_ready;
    assign io_bus.o_valid    = r_valid;
    assign io_bus.o_chars    = r_chars;
    assign io_bus.o_overflow = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_fixed_to_ascii_converter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fixed_to_ascii_converter
// Description : Self-checking bench: default converter plus a 5-integer-bit,
//               1-digit instance, both compared against a decimal reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fixed_to_ascii_converter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    fixed_to_ascii_converter_if #(.BITS(33), .NCHAR(8)) ba ();
    fixed_to_ascii_converter_if #(.BITS(35), .NCHAR(7)) bb ();

    fixed_to_ascii_converter #(
        .INT_BITS(3), .FRACTIONAL_BITS(30), .DISPLAY_INT_NUM(2), .DISPLAY_FRAC_NUM(4)
    ) dut_a (.i_clk(clk), .i_rst_n(rst_n), .io_bus(ba.slave));

    fixed_to_ascii_converter #(
        .INT_BITS(5), .FRACTIONAL_BITS(30), .DISPLAY_INT_NUM(1), .DISPLAY_FRAC_NUM(4)
    ) dut_b (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bb.slave));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic get_valid(input int sel);
        return (sel != 0) ? bb.o_valid : ba.o_valid;
    endfunction
    function automatic logic get_ready(input int sel);
        return (sel != 0) ? bb.o_ready : ba.o_ready;
    endfunction
    function automatic logic get_ovf(input int sel);
        return (sel != 0) ? bb.o_overflow : ba.o_overflow;
    endfunction
    function automatic logic [63:0] get_chars(input int sel);
        return (sel != 0) ? {8'h00, bb.o_chars} : ba.o_chars;
    endfunction

    // Decimal reference: integer/fraction split, division for integer digits,
    // repeated multiply-by-ten for truncated fraction digits.
    function automatic logic [63:0] model(input longint v, input int sel, output logic ovf);
        int         di = (sel != 0) ? 1 : 2;
        int         n  = di + 6;
        int         lead = 0;
        longint     mag, ip, fr, lim, tmp;
        logic       neg;
        logic [7:0] ch [8];
        int         dig [4];
        logic [63:0] res = '0;
        neg = (v < 0);
        mag = neg ? -v : v;
        ip  = mag >> 30;
        fr  = mag & 64'h3FFF_FFFF;
        lim = 1;
        for (int i = 0; i < di; i++) lim = lim * 10;
        ovf = (ip >= lim);
        tmp = ip;
        for (int j = di - 1; j >= 0; j--) begin
            dig[j] = int'(tmp % 10);
            tmp    = tmp / 10;
        end
`ifdef F2A_BLANK_ZEROS_EN
        if (!ovf) while (lead < di - 1 && dig[lead] == 0) lead++;
`endif
        for (int p = 0; p <= di; p++) begin
            if (p < lead)       ch[p] = 8'h20;
            else if (p == lead) ch[p] = neg ? 8'h2D : 8'h2B;
            else                ch[p] = ovf ? 8'h39 : 8'(8'h30 + dig[p-1]);
        end
        ch[di+1] = 8'h2E;
        for (int j = 0; j < 4; j++) begin
            fr = fr * 10;
            ch[di+2+j] = ovf ? 8'h39 : 8'(8'h30 + (fr >> 30));
            fr = fr & 64'h3FFF_FFFF;
        end
        for (int i = 0; i < n; i++) res = (res << 8) | 64'(ch[i]);
        return res;
    endfunction

    task automatic start(input int sel, input longint v);
        int n = 0;
        while (!get_ready(sel) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("accept_ready", 64'(get_ready(sel)), 64'd1);
        @(negedge clk);
        if (sel != 0) begin bb.i_value = v[34:0]; bb.i_valid = 1'b1; end
        else          begin ba.i_value = v[32:0]; ba.i_valid = 1'b1; end
        @(posedge clk); #1;
        ba.i_valid = 1'b0;
        bb.i_valid = 1'b0;
        check("ready_drop", 64'(get_ready(sel)), 64'd0);
    endtask

    task automatic wait_result(input int sel, input longint v, output logic [63:0] e);
        int   lat = 0;
        logic eo;
        while (!get_valid(sel) && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        e = model(v, sel, eo);
        check("latency", 64'(lat), (sel != 0) ? 64'd11 : 64'd9);
        check("chars", get_chars(sel), e);
        check("overflow", 64'(get_ovf(sel)), 64'(eo));
        check("busy_ready", 64'(get_ready(sel)), 64'd0);
    endtask

    task automatic finish_hs(input int sel, input logic [63:0] e);
        @(negedge clk);
        if (sel != 0) bb.i_ready = 1'b1; else ba.i_ready = 1'b1;
        @(posedge clk); #1;
        ba.i_ready = 1'b0;
        bb.i_ready = 1'b0;
        check("hs_valid", 64'(get_valid(sel)), 64'd0);
        check("hs_ready", 64'(get_ready(sel)), 64'd1);
        check("hs_chars_held", get_chars(sel), e);
    endtask

    task automatic convert(input int sel, input longint v);
        logic [63:0] e;
        start(sel, v);
        wait_result(sel, v, e);
        finish_hs(sel, e);
    endtask

    function automatic longint rand_a();
        logic [32:0] r = 33'({$urandom, $urandom});
        return {{31{r[32]}}, r};
    endfunction
    function automatic longint rand_b();
        logic [34:0] r = 35'({$urandom, $urandom});
        return {{29{r[34]}}, r};
    endfunction

    initial begin
        logic [63:0] e, e2;
        longint      v, nv;
        logic        ok;
        ba.i_valid = 1'b0; ba.i_value = '0; ba.i_ready = 1'b0;
        bb.i_valid = 1'b0; bb.i_value = '0; bb.i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(ba.o_valid), 64'd0);
        check("rst_ready", 64'(ba.o_ready), 64'd0);
        check("rst_ovf", 64'(ba.o_overflow), 64'd0);
        check("rst_chars", ba.o_chars, {8{8'h20}});
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", 64'(ba.o_ready), 64'd1);

        convert(0, 64'sd837518622);
        convert(0, -64'sd1610612736);
        convert(0, -64'sd4294967296);
        convert(0, 64'sd0);
        convert(0, -64'sd1);
        convert(0, 64'sd4294967295);
        convert(1, 64'sd13153337344);
        convert(1, 64'sd10737418239);
        convert(1, 64'sd10737418240);
        convert(1, -64'sd17179869184);
        for (int i = 0; i < 12; i++) convert(0, rand_a());
        for (int i = 0; i < 6; i++)  convert(1, rand_b());

        // Consumer stall with ignored input pulses, then same-cycle release
        v = rand_a();
        start(0, v);
        wait_result(0, v, e);
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ba.i_valid = 1'($urandom_range(0, 1));
            ba.i_value = 33'({$urandom, $urandom});
            @(posedge clk); #1;
            if (ba.o_valid !== 1'b1 || ba.o_chars !== e || ba.o_ready !== 1'b0) ok = 1'b0;
        end
        check("hold_stable", 64'(ok), 64'd1);
        nv = rand_a();
        @(negedge clk);
        ba.i_valid = 1'b1;
        ba.i_value = nv[32:0];
        ba.i_ready = 1'b1;
        @(posedge clk); #1;
        ba.i_ready = 1'b0;
        check("release_valid", 64'(ba.o_valid), 64'd0);
        check("release_ready", 64'(ba.o_ready), 64'd1);
        @(posedge clk); #1;
        ba.i_valid = 1'b0;
        check("late_accept", 64'(ba.o_ready), 64'd0);
        wait_result(0, nv, e2);
        finish_hs(0, e2);

        // Reset in the middle of a conversion
        start(0, rand_a());
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", 64'(ba.o_valid), 64'd0);
        check("abort_chars", ba.o_chars, {8{8'h20}});
        check("abort_ready", 64'(ba.o_ready), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_no_output", 64'(ba.o_valid), 64'd0);
        convert(0, 64'sd837518622);
        convert(0, rand_a());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
